// File: rtl/life_pkg.sv
// life_pkg: shared loader state encoding, row-select width and row byte sizing
package life_pkg;
    typedef enum logic [2:0] {S_HDR, S_ROW, S_WRITE, S_START, S_WAIT, S_DONE} loader_state_t;
    localparam int ROW_SEL_W = 8;
    function automatic int bytes_per_row(input int width);
        return (width + 7) / 8;
    endfunction
endpackage

// File: rtl/row_assembler.sv
// row_assembler: byte counter and row buffer; byte k lands in bits [8k+7:8k], bits past ARENA_WIDTH dropped
module row_assembler import life_pkg::*; #(
    parameter int ARENA_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_en,
    input  logic [7:0]             byte_in,
    output logic [ARENA_WIDTH-1:0] row,
    output logic                   row_full
);
    localparam int BPR = bytes_per_row(ARENA_WIDTH);
    localparam int CW  = $clog2(BPR + 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            cnt <= '0;
            row <= '0;
        end else if (byte_en) begin
            for (int b = 0; b < ARENA_WIDTH; b++)
                if (cnt == CW'(b / 8)) row[b] <= byte_in[b % 8];
            cnt <= cnt + 1'b1;
        end
    end
    assign row_full = cnt == CW'(BPR - 1);
endmodule

// File: rtl/arena_loader.sv
// arena_loader: byte-stream frame loader that fills the arena row by row, then launches and waits for the solver
module arena_loader import life_pkg::*; #(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ROW_SEL_W-1:0]   load_row_select,
    output logic [ARENA_WIDTH-1:0] load_columns,
    output logic                   load_write,
    output logic                   solver_start,
    input  logic                   solver_ready,
    output logic [31:0]            generations_count,
    output logic                   frame_done
);
    loader_state_t state;
    logic [1:0] hdr_cnt;
    logic [ROW_SEL_W-1:0] row;
    logic wait_first, take, clear, byte_en, row_full;
    logic [ARENA_WIDTH-1:0] row_bits;
    row_assembler #(.ARENA_WIDTH(ARENA_WIDTH)) u_asm (
        .clk(clk), .reset(reset), .clear(clear), .byte_en(byte_en),
        .byte_in(in_data), .row(row_bits), .row_full(row_full)
    );
    always_comb begin
        in_ready        = state == S_HDR || state == S_ROW;
        take            = in_valid && in_ready;
        byte_en         = take && state == S_ROW;
        clear           = (take && state == S_HDR && hdr_cnt == 2'd3) || state == S_WRITE;
        load_write      = state == S_WRITE;
        load_row_select = load_write ? row : '0;
        load_columns    = load_write ? row_bits : '0;
        solver_start    = state == S_START && solver_ready;
        frame_done      = state == S_DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_HDR;
            hdr_cnt           <= '0;
            row               <= '0;
            wait_first        <= 1'b0;
            generations_count <= '0;
        end else begin
            case (state)
                S_HDR: if (take) begin
                    generations_count <= {in_data, generations_count[31:8]};
                    hdr_cnt           <= hdr_cnt + 2'd1;
                    if (hdr_cnt == 2'd3) begin
                        row   <= '0;
                        state <= S_ROW;
                    end
                end
                S_ROW: if (byte_en && row_full) state <= S_WRITE;
                S_WRITE: if (row == ROW_SEL_W'(ARENA_HEIGHT - 1))
                    state <= generations_count == '0 ? S_DONE : S_START;
                else begin
                    row   <= row + 1'b1;
                    state <= S_ROW;
                end
                S_START: if (solver_ready) begin
                    wait_first <= 1'b1;
                    state      <= S_WAIT;
                end
                S_WAIT: if (wait_first) wait_first <= 1'b0;
                else if (solver_ready) state <= S_DONE;
                S_DONE: state <= S_HDR;
                default: state <= S_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_arena_loader.sv
// tb_arena_loader: directed frames with a row-write scoreboard and a simple solver model
module tb_arena_loader;
    localparam int W = 10;
    localparam int H = 10;
    typedef struct packed {
        logic [7:0]   r;
        logic [W-1:0] c;
    } wr_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] in_data = '0;
    logic in_valid = 1'b0;
    logic in_ready, load_write, solver_start, solver_ready, frame_done;
    logic [7:0] load_row_select;
    logic [W-1:0] load_columns;
    logic [31:0] generations_count;
    wr_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0, starts = 0, dones = 0, last_wr = 0, busy = 0;
    bit busy_phase = 0, zero_mode = 0, hold = 0;
    logic [31:0] exp_gen = '0;

    arena_loader #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .load_row_select(load_row_select), .load_columns(load_columns), .load_write(load_write),
        .solver_start(solver_start), .solver_ready(solver_ready),
        .generations_count(generations_count), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign solver_ready = !hold && busy == 0;
    always @(posedge clk or posedge reset)
        if (reset) busy <= 0;
        else if (solver_start) busy <= 4;
        else if (busy > 0) busy <= busy - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (reset) busy_phase = 0;
        else begin
            if (busy_phase) check("in_ready_low_after_last_write", in_ready, 0);
            if (load_write) begin
                check("write_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("row_select", load_row_select, e.r);
                    check("columns", load_columns, e.c);
                end
                if (load_row_select == 8'(H - 1)) begin
                    busy_phase = 1;
                    last_wr = cyc;
                end
            end
            if (solver_start) begin
                starts++;
                check("no_start_when_zero_gen", zero_mode, 0);
            end
            if (frame_done) begin
                dones++;
                busy_phase = 0;
                check("done_generations", generations_count, exp_gen);
                if (zero_mode) check("zero_gen_done_latency", cyc - last_wr, 1);
            end
        end
    end

    function automatic logic [15:0] row_val(input int mode, input int i);
        return mode == 0 ? 16'h0355 :
               mode == 1 ? (i[0] ? 16'hFCFF : 16'hFFFF) :
               {8'(i ^ 5), 8'(i * 17 + 3)};
    endfunction

    task automatic send(input logic [7:0] b, input bit gap);
        int t = 0;
        @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("send_timeout", t, 0);
        @(posedge clk);
        if (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_hdr(input logic [31:0] g, input bit gap);
        for (int k = 0; k < 4; k++) send(g[8*k +: 8], gap);
    endtask

    task automatic send_rows(input int mode, input int n, input bit gap);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = row_val(mode, i);
            exp_q.push_back('{r: 8'(i), c: v[W-1:0]});
            send(v[7:0], gap);
            send(v[15:8], gap);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t = 0;
        while (dones < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_seen", dones >= target, 1);
    endtask

    initial begin
        logic [15:0] v;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_load_write", load_write, 0);
        check("rst_row_select", load_row_select, 0);
        check("rst_columns", load_columns, 0);
        check("rst_solver_start", solver_start, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_generations", generations_count, 0);

        exp_gen = 32'd5;
        send_hdr(32'd5, 0);
        send_rows(0, H, 0);
        idle();
        wait_done(1);
        check("nominal_generations", generations_count, 32'd5);
        check("nominal_starts", starts, 1);
        check("nominal_queue_empty", exp_q.size(), 0);

        exp_gen = 32'd1;
        send_hdr(32'd1, 0);
        send_rows(1, H, 0);
        idle();
        wait_done(2);
        check("mask_starts", starts, 2);

        zero_mode = 1;
        exp_gen = 32'd0;
        send_hdr(32'd0, 0);
        send_rows(2, H, 0);
        idle();
        wait_done(3);
        zero_mode = 0;
        check("zero_gen_starts", starts, 2);

        hold = 1;
        exp_gen = 32'hFFFF_FFFF;
        send_hdr(32'hFFFF_FFFF, 1);
        send_rows(2, H, 1);
        repeat (20) @(negedge clk);
        check("bp_start_held", starts, 2);
        check("bp_in_ready_held", in_ready, 0);
        hold = 0;
        wait_done(4);
        check("bp_single_start", starts, 3);
        check("bp_generations", generations_count, 32'hFFFF_FFFF);
        check("bp_queue_empty", exp_q.size(), 0);

        exp_gen = 32'd7;
        send_hdr(32'd7, 0);
        send_rows(2, 4, 0);
        v = row_val(2, 4);
        send(v[7:0], 0);
        #1;
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_load_write", load_write, 0);
        check("midrst_columns", load_columns, 0);
        check("midrst_generations", generations_count, 0);
        check("midrst_frame_done", frame_done, 0);
        check("midrst_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        exp_gen = 32'd2;
        send_hdr(32'd2, 0);
        send_rows(1, H, 0);
        idle();
        wait_done(5);
        check("midrst_new_frame_starts", starts, 4);

        exp_gen = 32'd3;
        send_hdr(32'd3, 0);
        send_rows(0, H, 0);
        send(8'h0D, 0);
        check("b2b_header_after_done", dones, 6);
        send(8'h0C, 0);
        send(8'h0B, 0);
        #1;
        check("b2b_gen_not_yet", generations_count != 32'h0A0B_0C0D, 1);
        send(8'h0A, 0);
        #1;
        check("b2b_gen_switched", generations_count, 32'h0A0B_0C0D);
        exp_gen = 32'h0A0B_0C0D;
        send_rows(1, H, 0);
        idle();
        wait_done(7);
        check("b2b_starts", starts, 6);
        check("b2b_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
